// File: rtl/cosmem_pkg.sv
// Shared definitions for the COSMAC bus initiator: machine-cycle phase encoding,
// bus-output bundle and the per-phase bus decode.
package cosmem_pkg;

  // P0..P7 share their numeric phase with the low three bits; IDLE sits above them.
  typedef enum logic [3:0] {
    P0   = 4'd0,
    P1   = 4'd1,
    P2   = 4'd2,
    P3   = 4'd3,
    P4   = 4'd4,
    P5   = 4'd5,
    P6   = 4'd6,
    P7   = 4'd7,
    IDLE = 4'd8
  } phase_e;

  localparam logic [2:0] TPA_PHASE   = 3'd0;
  localparam logic [2:0] TPB_PHASE   = 3'd6;
  localparam logic [2:0] WAIT_PHASE  = 3'd4;
  localparam logic [2:0] NMWR_FIRST  = 3'd5;
  localparam logic [2:0] NMWR_LAST   = 3'd6;
  localparam logic [2:0] DB_OE_FIRST = 3'd2;

  typedef struct packed {
    logic       tpa;
    logic       tpb;
    logic [7:0] ma;
    logic       nmrd;
    logic       nmwr;
    logic       db_oe;
    logic [7:0] db_do;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    tpa:   1'b0,
    tpb:   1'b0,
    ma:    8'h00,
    nmrd:  1'b1,
    nmwr:  1'b1,
    db_oe: 1'b0,
    db_do: 8'h00
  };

  function automatic phase_e phase_of(input logic [2:0] n);
    return phase_e'({1'b0, n});
  endfunction

  function automatic bus_t bus_decode(input phase_e     ph,
                                      input logic       wr,
                                      input logic [15:0] addr,
                                      input logic [7:0] wdata);
    bus_t       b;
    logic [2:0] p;
    b = BUS_IDLE;
    p = ph[2:0];
    if (ph != IDLE) begin
      b.tpa   = (p == TPA_PHASE);
      b.tpb   = (p == TPB_PHASE);
      b.ma    = (p == TPA_PHASE) ? addr[15:8] : addr[7:0];
      b.nmrd  = wr || (p == TPA_PHASE);
      b.nmwr  = !(wr && (p >= NMWR_FIRST) && (p <= NMWR_LAST));
      b.db_oe = wr && (p >= DB_OE_FIRST);
      b.db_do = b.db_oe ? wdata : 8'h00;
    end
    return b;
  endfunction

endpackage

// File: rtl/xclk_sync.sv
// Synchronises the memory chip's XCLK, NWAIT and CLR into the clk domain and
// produces a one-clk tick on each rising edge of the synchronised XCLK.
module xclk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic xclk,
  input  logic nwait,
  input  logic clr,
  output logic tick,
  output logic nwait_s,
  output logic clr_s
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("xclk_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] xclk_r;
  logic [SYNC_STAGES-1:0] nwait_r;
  logic [SYNC_STAGES-1:0] clr_r;
  logic                   xclk_d;

  // NWAIT and CLR come out of reset in their inactive (high) state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xclk_r  <= '0;
      nwait_r <= '1;
      clr_r   <= '1;
      xclk_d  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      xclk_r  <= {xclk_r[SYNC_STAGES-2:0], xclk};
      nwait_r <= {nwait_r[SYNC_STAGES-2:0], nwait};
      clr_r   <= {clr_r[SYNC_STAGES-2:0], clr};
      xclk_d  <= xclk_r[SYNC_STAGES-1];
    end
  end

  assign tick    = xclk_r[SYNC_STAGES-1] & ~xclk_d;
  assign nwait_s = nwait_r[SYNC_STAGES-1];
  assign clr_s   = clr_r[SYNC_STAGES-1];

endmodule

// File: rtl/cosmac_bus_master.sv
// COSMAC 1802-style bus initiator: runs request/response transfers as 8-phase XCLK-paced machine cycles.
// Optional: define COSMAC_BUS_WAIT_TIMEOUT_EN to add rsp_err and a bounded wait in P4.
module cosmac_bus_master
  import cosmem_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_MAX    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        xclk,
  input  logic        nwait,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
  output logic        rsp_err,
`endif
  output logic        tpa,
  output logic        tpb,
  output logic [7:0]  ma,
  output logic        nmrd,
  output logic        nmwr,
  output logic        db_oe,
  output logic [7:0]  db_do,
  input  logic [7:0]  db_di
);

  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
    $error("cosmac_bus_master: WAIT_MAX must be in 1..255");
  end

  localparam phase_e WAIT_ST = phase_of(WAIT_PHASE);

  logic tick;
  logic nwait_s;
  logic clr_s;

  xclk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .xclk    (xclk),
    .nwait   (nwait),
    .clr     (clr),
    .tick    (tick),
    .nwait_s (nwait_s),
    .clr_s   (clr_s)
  );

  phase_e      state, state_nxt;
  logic        wr_q, wr_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [7:0]  wdata_q, wdata_nxt;
  logic [7:0]  rdata_q, rdata_nxt;
  bus_t        bus_q, bus_nxt;
  logic        accept;

`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
  logic [7:0] wait_cnt;

  // Counts consecutive stalled P4 ticks; restarts on every entry to P4.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_nxt == WAIT_ST && state != WAIT_ST) begin
      wait_cnt <= '0;
    end else if (tick && clr_s && state == WAIT_ST && !nwait_s) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    wr_nxt    = wr_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    rdata_nxt = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
    rsp_err   = 1'b0;
`endif

    if (!clr_s) begin
      // CLEAR drops any cycle in flight and blocks new requests.
      state_nxt = IDLE;
    end else if (tick) begin
      case (state)
        IDLE: accept = req_valid;
        WAIT_ST: begin
          if (nwait_s) begin
            state_nxt = P5;
          end
`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            state_nxt = IDLE;
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
          end
`endif
        end
        P6: begin
          state_nxt = P7;
          if (!wr_q) rdata_nxt = db_di;
        end
        P7: begin
          state_nxt = IDLE;
          rsp_valid = 1'b1;
          accept    = req_valid;
        end
        default: state_nxt = phase_e'(state + 4'd1);
      endcase

      // Read data is cleared on acceptance so writes and aborts report zero.
      if (accept) begin
        req_ready = 1'b1;
        state_nxt = P0;
        wr_nxt    = req_write;
        addr_nxt  = req_addr;
        wdata_nxt = req_wdata;
        rdata_nxt = 8'h00;
      end
    end

    bus_nxt = bus_decode(state_nxt, wr_nxt, addr_nxt, wdata_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bus_q   <= BUS_IDLE;
    end else begin
      state   <= state_nxt;
      wr_q    <= wr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
      bus_q   <= bus_nxt;
    end
  end

  assign rsp_rdata = rdata_q;
  assign tpa       = bus_q.tpa;
  assign tpb       = bus_q.tpb;
  assign ma        = bus_q.ma;
  assign nmrd      = bus_q.nmrd;
  assign nmwr      = bus_q.nmwr;
  assign db_oe     = bus_q.db_oe;
  assign db_do     = bus_q.db_do;

endmodule

// File: tb/tb_cosmac_bus_master.sv
// Directed bench for cosmac_bus_master: XCLK is stepped one bus tick at a time and
// bus outputs are compared against hand-written per-phase tables.
module tb_cosmac_bus_master;

  logic        clk = 1'b0;
  logic        reset, xclk, nwait, clr;
  logic        req_valid, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, db_di;
  logic        req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
  logic        rsp_err;
  logic        rsp_e;
`endif
  logic        tpa, tpb, nmrd, nmwr, db_oe;
  logic [7:0]  ma, db_do;
  logic [20:0] bus;

  localparam logic [20:0] IDLE_BUS = {5'b00110, 8'h00, 8'h00};

  assign bus = {tpa, tpb, nmrd, nmwr, db_oe, ma, db_do};

  always #5 clk = ~clk;

  cosmac_bus_master #(
    .SYNC_STAGES(2),
    .WAIT_MAX(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .xclk      (xclk),
    .nwait     (nwait),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
    .rsp_err   (rsp_err),
`endif
    .tpa       (tpa),
    .tpb       (tpb),
    .ma        (ma),
    .nmrd      (nmrd),
    .nmwr      (nmwr),
    .db_oe     (db_oe),
    .db_do     (db_do),
    .db_di     (db_di)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t       q[$];
  bit         pop_pending = 1'b0;
  int         tests_run = 0, tests_failed = 0;
  int         tick_no = 0, rsp_cnt = 0, ready_cnt = 0, both_cnt = 0;
  int         rsp_tick = 0, ready_tick = 0;
  logic [7:0] rsp_data = 8'h00;

  task automatic apply_req();
    if (q.size() > 0) begin
      req_valid = 1'b1;
      req_write = q[0].wr;
      req_addr  = q[0].addr;
      req_wdata = q[0].wdata;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic push(input logic wr, input logic [15:0] a, input logic [7:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = d;
    q.push_back(r);
    apply_req();
  endtask

  // Called on every falling edge: logs handshakes, retires accepted requests after the capture edge.
  task automatic sample();
    if (pop_pending) begin
      if (q.size() > 0) q.delete(0);
      pop_pending = 1'b0;
      apply_req();
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_tick = tick_no;
      rsp_data = rsp_rdata;
`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
      rsp_e = rsp_err;
`endif
      if (req_ready) both_cnt++;
    end
    if (req_ready) begin
      ready_cnt++;
      ready_tick  = tick_no;
      pop_pending = 1'b1;
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
    end
  endtask

  // One full XCLK period; the tick and resulting bus update land well inside it.
  task automatic xtick();
    xclk = 1'b1;
    tick_no++;
    clocks(8);
    xclk = 1'b0;
    clocks(8);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({req_ready, rsp_valid, rsp_rdata, bus} !== {2'b00, 8'h00, IDLE_BUS}) begin
      tests_failed++;
      $display("FAIL reset_values got %h want %h", {req_ready, rsp_valid, rsp_rdata, bus},
               {2'b00, 8'h00, IDLE_BUS});
    end
  endtask

  task automatic test_read();
    logic [20:0] exp [9];
    int c0;
    exp = '{{5'b10110, 8'h12, 8'h00}, {5'b00010, 8'h34, 8'h00}, {5'b00010, 8'h34, 8'h00},
            {5'b00010, 8'h34, 8'h00}, {5'b00010, 8'h34, 8'h00}, {5'b00010, 8'h34, 8'h00},
            {5'b01010, 8'h34, 8'h00}, {5'b00010, 8'h34, 8'h00}, {5'b00110, 8'h00, 8'h00}};
    db_di = 8'h3C;
    c0 = rsp_cnt;
    push(1'b0, 16'h1234, 8'h00);
    for (int i = 0; i < 9; i++) begin
      xtick();
      if (i == 1) db_di = 8'hA5;
      tests_run++;
      if (bus !== exp[i]) begin
        tests_failed++;
        $display("FAIL read_phase%0d bus got %h want %h", i, bus, exp[i]);
      end
    end
    tests_run++;
    if ((rsp_cnt - c0) !== 1 || (rsp_tick - ready_tick) !== 8) begin
      tests_failed++;
      $display("FAIL read_rsp_timing got count %0d latency %0d want 1 and 8", rsp_cnt - c0,
               rsp_tick - ready_tick);
    end
    tests_run++;
    if (rsp_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL read_rdata got %h want a5", rsp_data);
    end
  endtask

  task automatic test_write();
    logic [20:0] exp [9];
    int c0;
    exp = '{{5'b10110, 8'hBE, 8'h00}, {5'b00110, 8'hEF, 8'h00}, {5'b00111, 8'hEF, 8'h5A},
            {5'b00111, 8'hEF, 8'h5A}, {5'b00111, 8'hEF, 8'h5A}, {5'b00101, 8'hEF, 8'h5A},
            {5'b01101, 8'hEF, 8'h5A}, {5'b00111, 8'hEF, 8'h5A}, {5'b00110, 8'h00, 8'h00}};
    c0 = rsp_cnt;
    push(1'b1, 16'hBEEF, 8'h5A);
    for (int i = 0; i < 9; i++) begin
      xtick();
      tests_run++;
      if (bus !== exp[i]) begin
        tests_failed++;
        $display("FAIL write_phase%0d bus got %h want %h", i, bus, exp[i]);
      end
    end
    tests_run++;
    if ((rsp_cnt - c0) !== 1 || (rsp_tick - ready_tick) !== 8 || rsp_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL write_rsp got count %0d latency %0d rdata %h want 1 8 00", rsp_cnt - c0,
               rsp_tick - ready_tick, rsp_data);
    end
  endtask

  task automatic test_wait();
    logic [20:0] exp [12];
    int c0;
    exp = '{{5'b10110, 8'hC0, 8'h00}, {5'b00010, 8'hDE, 8'h00}, {5'b00010, 8'hDE, 8'h00},
            {5'b00010, 8'hDE, 8'h00}, {5'b00010, 8'hDE, 8'h00}, {5'b00010, 8'hDE, 8'h00},
            {5'b00010, 8'hDE, 8'h00}, {5'b00010, 8'hDE, 8'h00}, {5'b00010, 8'hDE, 8'h00},
            {5'b01010, 8'hDE, 8'h00}, {5'b00010, 8'hDE, 8'h00}, {5'b00110, 8'h00, 8'h00}};
    db_di = 8'h77;
    c0 = rsp_cnt;
    push(1'b0, 16'hC0DE, 8'h00);
    for (int i = 0; i < 12; i++) begin
      xtick();
      if (i == 4) nwait = 1'b0;
      if (i == 7) nwait = 1'b1;
      tests_run++;
      if (bus !== exp[i]) begin
        tests_failed++;
        $display("FAIL wait_step%0d bus got %h want %h", i, bus, exp[i]);
      end
    end
    tests_run++;
    if ((rsp_cnt - c0) !== 1 || (rsp_tick - ready_tick) !== 11 || rsp_data !== 8'h77) begin
      tests_failed++;
      $display("FAIL wait_rsp got count %0d latency %0d rdata %h want 1 11 77", rsp_cnt - c0,
               rsp_tick - ready_tick, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    int c0, b0, first_ready;
    c0 = rsp_cnt;
    b0 = both_cnt;
    db_di = 8'h99;
    push(1'b1, 16'h0001, 8'h11);
    push(1'b0, 16'h0002, 8'h00);
    repeat (8) xtick();
    first_ready = ready_tick;
    xtick();
    tests_run++;
    if (bus !== {5'b10110, 8'h00, 8'h00}) begin
      tests_failed++;
      $display("FAIL b2b_second_p0 bus got %h want %h", bus, {5'b10110, 8'h00, 8'h00});
    end
    tests_run++;
    if ((both_cnt - b0) !== 1 || rsp_tick !== ready_tick || (ready_tick - first_ready) !== 8) begin
      tests_failed++;
      $display("FAIL b2b_handshake got coincide %0d rsp_tick %0d ready_tick %0d gap %0d want 1 equal 8",
               both_cnt - b0, rsp_tick, ready_tick, ready_tick - first_ready);
    end
    tests_run++;
    if (rsp_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL b2b_write_rdata got %h want 00", rsp_data);
    end
    xtick();
    tests_run++;
    if (bus !== {5'b00010, 8'h02, 8'h00}) begin
      tests_failed++;
      $display("FAIL b2b_second_p1 bus got %h want %h", bus, {5'b00010, 8'h02, 8'h00});
    end
    repeat (7) xtick();
    tests_run++;
    if ((rsp_cnt - c0) !== 2 || (rsp_tick - ready_tick) !== 8 || rsp_data !== 8'h99 || bus !== IDLE_BUS) begin
      tests_failed++;
      $display("FAIL b2b_second_rsp got count %0d latency %0d rdata %h bus %h want 2 8 99 %h",
               rsp_cnt - c0, rsp_tick - ready_tick, rsp_data, bus, IDLE_BUS);
    end
  endtask

  task automatic test_clr();
    int c0, r0;
    c0 = rsp_cnt;
    push(1'b1, 16'h1357, 8'hC3);
    repeat (4) xtick();
    tests_run++;
    if (bus !== {5'b00111, 8'h57, 8'hC3}) begin
      tests_failed++;
      $display("FAIL clr_p3_before bus got %h want %h", bus, {5'b00111, 8'h57, 8'hC3});
    end
    clr = 1'b0;
    clocks(4);
    tests_run++;
    if (bus !== IDLE_BUS) begin
      tests_failed++;
      $display("FAIL clr_forces_idle bus got %h want %h", bus, IDLE_BUS);
    end
    r0 = ready_cnt;
    push(1'b0, 16'h2468, 8'h00);
    repeat (2) xtick();
    tests_run++;
    if ((ready_cnt - r0) !== 0 || (rsp_cnt - c0) !== 0 || bus !== IDLE_BUS) begin
      tests_failed++;
      $display("FAIL clr_blocks got accepts %0d rsps %0d bus %h want 0 0 %h", ready_cnt - r0,
               rsp_cnt - c0, bus, IDLE_BUS);
    end
    clr = 1'b1;
    clocks(4);
    db_di = 8'h5E;
    xtick();
    tests_run++;
    if (bus !== {5'b10110, 8'h24, 8'h00}) begin
      tests_failed++;
      $display("FAIL clr_resume_p0 bus got %h want %h", bus, {5'b10110, 8'h24, 8'h00});
    end
    repeat (8) xtick();
    tests_run++;
    if ((rsp_cnt - c0) !== 1 || rsp_data !== 8'h5E || bus !== IDLE_BUS) begin
      tests_failed++;
      $display("FAIL clr_resume_rsp got count %0d rdata %h bus %h want 1 5e %h", rsp_cnt - c0,
               rsp_data, bus, IDLE_BUS);
    end
  endtask

`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
  task automatic test_timeout();
    int c0;
    c0 = rsp_cnt;
    db_di = 8'h88;
    push(1'b0, 16'h4455, 8'h00);
    repeat (5) xtick();
    nwait = 1'b0;
    repeat (3) xtick();
    tests_run++;
    if ((rsp_cnt - c0) !== 0 || bus !== {5'b00010, 8'h55, 8'h00}) begin
      tests_failed++;
      $display("FAIL timeout_early got rsps %0d bus %h want 0 %h", rsp_cnt - c0, bus,
               {5'b00010, 8'h55, 8'h00});
    end
    xtick();
    tests_run++;
    if ((rsp_cnt - c0) !== 1 || rsp_e !== 1'b1 || rsp_data !== 8'h00 || bus !== IDLE_BUS ||
        (rsp_tick - ready_tick) !== 8) begin
      tests_failed++;
      $display("FAIL timeout_abort got count %0d err %b rdata %h bus %h latency %0d want 1 1 00 %h 8",
               rsp_cnt - c0, rsp_e, rsp_data, bus, rsp_tick - ready_tick, IDLE_BUS);
    end
    nwait = 1'b1;
    db_di = 8'h66;
    push(1'b0, 16'h0A0B, 8'h00);
    repeat (9) xtick();
    tests_run++;
    if ((rsp_cnt - c0) !== 2 || rsp_e !== 1'b0 || rsp_data !== 8'h66) begin
      tests_failed++;
      $display("FAIL timeout_recover got count %0d err %b rdata %h want 2 0 66", rsp_cnt - c0,
               rsp_e, rsp_data);
    end
  endtask
`endif

  task automatic test_reset_mid();
    push(1'b0, 16'hFFFF, 8'h00);
    repeat (3) xtick();
    tests_run++;
    if (bus !== {5'b00010, 8'hFF, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_mid_before bus got %h want %h", bus, {5'b00010, 8'hFF, 8'h00});
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_rdata, bus} !== {2'b00, 8'h00, IDLE_BUS}) begin
      tests_failed++;
      $display("FAIL reset_mid_async got %h want %h", {req_ready, rsp_valid, rsp_rdata, bus},
               {2'b00, 8'h00, IDLE_BUS});
    end
    q.delete();
    pop_pending = 1'b0;
    apply_req();
    clocks(3);
    reset = 1'b0;
    xtick();
    tests_run++;
    if (bus !== IDLE_BUS) begin
      tests_failed++;
      $display("FAIL reset_mid_after bus got %h want %h", bus, IDLE_BUS);
    end
  endtask

  initial begin
    reset     = 1'b1;
    xclk      = 1'b0;
    nwait     = 1'b1;
    clr       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    db_di     = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    clocks(4);
    test_read();
    test_write();
    test_wait();
    test_back_to_back();
    test_clr();
`ifdef COSMAC_BUS_WAIT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
